// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, NOP encoding and skid-stage state enum
package pipe_pkg;
    localparam int PIPE_ADDR_W = 32;
    localparam int PIPE_INSN_W = 32;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTRL_W = 22;
    localparam logic [31:0] PIPE_NOP_INSN = 32'h6800_0000;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } pipe_state_e;
endpackage

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg: load-enabled payload register for one skid-buffer entry
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    // capture the beat only when told to, otherwise hold through stalls
    always_ff @(posedge clk) begin
        if (reset) r_q <= '0;
        else if (i_load) r_q <= i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: inter-stage register with 2-entry skid buffer, flush and loss counter
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int ADDR_W  = PIPE_ADDR_W,
    parameter int INSN_W  = PIPE_INSN_W,
    parameter int DATA_W  = PIPE_DATA_W,
    parameter int NUM_OPS = 3,
    parameter int CTRL_W  = PIPE_CTRL_W,
    parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(PIPE_NOP_INSN),
    parameter int CNT_W   = 16,
    localparam int OPS_W  = (NUM_OPS > 0) ? NUM_OPS * DATA_W : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_PC,
    input  logic [INSN_W-1:0] in_IR,
    input  logic [OPS_W-1:0]  in_ops,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_PC,
    output logic [INSN_W-1:0] out_IR,
    output logic [OPS_W-1:0]  out_ops,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int OP_BITS = NUM_OPS * DATA_W;
    localparam int PL_W    = ADDR_W + INSN_W + CTRL_W + OP_BITS;

    pipe_state_e      r_state;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_m_v, w_s_v, w_accept, w_drain, w_ld_m, w_ld_s;
    logic [PL_W-1:0]  w_in_pl, w_m_d, w_m_q, w_s_q;
    logic [1:0]       w_lost;
    logic [CNT_W+1:0] w_cnt_sum;

    assign w_m_v    = r_state[1];
    assign w_s_v    = r_state[0];
    assign in_ready = ~w_s_v;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = w_m_v & out_ready;

    // M loads from input (EMPTY/ONE) or shifts up from S (FULL); a flush freezes both payloads
    assign w_ld_m = ~flush & ((r_state == FULL) ? w_drain : (w_accept & ((r_state == EMPTY) | w_drain)));
    assign w_ld_s = ~flush & (r_state == ONE) & w_accept & ~w_drain;
    assign w_m_d  = (r_state == FULL) ? w_s_q : w_in_pl;

    generate
        if (NUM_OPS > 0) begin : g_ops
            assign w_in_pl = {in_PC, in_IR, in_ctrl, in_ops};
            assign out_ops = w_m_q[OP_BITS-1:0];
        end else begin : g_no_ops
            assign w_in_pl = {in_PC, in_IR, in_ctrl};
            assign out_ops = '0;
        end
    endgenerate

    pipe_payload_reg #(.W(PL_W)) u_main (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_ld_m),
        .i_d    (w_m_d),
        .o_q    (w_m_q)
    );

    pipe_payload_reg #(.W(PL_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_ld_s),
        .i_d    (w_in_pl),
        .o_q    (w_s_q)
    );

    // occupancy FSM: flush empties both entries, otherwise track accept/drain
    always_ff @(posedge clk) begin
        if (reset || flush) r_state <= EMPTY;
        else begin
            unique case (r_state)
                EMPTY: if (w_accept) r_state <= ONE;
                ONE: begin
                    if (w_accept && !w_drain) r_state <= FULL;
                    else if (!w_accept && w_drain) r_state <= EMPTY;
                end
                FULL: if (w_drain) r_state <= ONE;
                default: r_state <= EMPTY;
            endcase
        end
    end

    // beats lost to a flush: held-but-not-draining entries plus any beat accepted that cycle
    assign w_lost    = 2'(w_m_v & ~w_drain) + 2'(w_s_v) + 2'(w_accept);
    assign w_cnt_sum = {2'b00, r_flush_cnt} + (CNT_W+2)'(w_lost);

    // saturating flush-loss counter, untouched by reset-time drops
    always_ff @(posedge clk) begin
        if (reset) r_flush_cnt <= '0;
        else if (flush) r_flush_cnt <= (w_cnt_sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end

    assign flush_cnt = r_flush_cnt;
    assign out_valid = w_m_v;
    assign out_PC    = w_m_q[OP_BITS+CTRL_W+INSN_W +: ADDR_W];
    assign out_IR    = w_m_v ? w_m_q[OP_BITS+CTRL_W +: INSN_W] : NOP_INSN;
    assign out_ctrl  = w_m_v ? w_m_q[OP_BITS +: CTRL_W] : '0;
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: queue-model checker plus directed vectors for the skid stage
module tb_pipe_stage_skid_reg;
    localparam logic [31:0] NOP = 32'h6800_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [95:0] ops;
        logic [21:0] ctrl;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_PC, in_IR;
    logic [95:0] in_ops;
    logic [21:0] in_ctrl;
    logic        in_ready, out_valid;
    logic [31:0] out_PC, out_IR;
    logic [95:0] out_ops;
    logic [21:0] out_ctrl;
    logic [15:0] flush_cnt;

    logic        in_ready2, out_valid2;
    logic [31:0] out_PC2, out_IR2;
    logic [0:0]  in_ops2, out_ops2;
    logic [21:0] out_ctrl2;
    logic [1:0]  flush_cnt2;

    int vec = 0;
    int miss = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_PC(in_PC), .in_IR(in_IR), .in_ops(in_ops), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_PC(out_PC), .out_IR(out_IR),
        .out_ops(out_ops), .out_ctrl(out_ctrl), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid_reg #(.NUM_OPS(0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_PC(in_PC), .in_IR(in_IR), .in_ops(in_ops2), .in_ctrl(in_ctrl),
        .out_valid(out_valid2), .out_ready(out_ready), .out_PC(out_PC2), .out_IR(out_IR2),
        .out_ops(out_ops2), .out_ctrl(out_ctrl2), .flush_cnt(flush_cnt2)
    );

    function automatic beat_t mk(input logic [31:0] pc);
        beat_t b;
        b.pc   = pc;
        b.ir   = 32'h1000_0000 | pc;
        b.ops  = {pc + 32'd3, pc + 32'd2, pc + 32'd1};
        b.ctrl = pc[21:0] ^ 22'h2A_AAAA;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic ordy, input logic fl, input logic rs);
        beat_t b;
        b = mk(pc);
        reset = rs; flush = fl; in_valid = v; out_ready = ordy;
        in_PC = b.pc; in_IR = b.ir; in_ops = b.ops; in_ctrl = b.ctrl; in_ops2 = 1'b0;
        @(posedge clk);
        #2;
    endtask

    // model: a FIFO of at most two beats; the front beat is what downstream sees
    beat_t       q[$];
    beat_t       m_reg = '0;
    int unsigned cnt1 = 0, cnt2 = 0;

    always @(posedge clk) begin
        bit acc, drn;
        int unsigned lost;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        if (reset) begin
            q.delete();
            m_reg = '0;
            cnt1 = 0;
            cnt2 = 0;
        end else if (flush) begin
            lost = q.size() - (drn ? 1 : 0) + (acc ? 1 : 0);
            cnt1 = (cnt1 + lost > 65535) ? 65535 : cnt1 + lost;
            cnt2 = (cnt2 + lost > 3) ? 3 : cnt2 + lost;
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back({in_PC, in_IR, in_ops, in_ctrl});
            if (q.size() > 0) m_reg = q[0];
        end
    end

    always @(negedge clk) begin
        bit v;
        if (chk_en) begin
            v = q.size() > 0;
            chk("out_valid", out_valid, v);
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_PC", out_PC, m_reg.pc);
            chk("out_IR", out_IR, v ? m_reg.ir : NOP);
            chk("out_ops", out_ops, m_reg.ops);
            chk("out_ctrl", out_ctrl, v ? m_reg.ctrl : 22'd0);
            chk("flush_cnt", flush_cnt, cnt1);
            chk("d2_out_valid", out_valid2, v);
            chk("d2_in_ready", in_ready2, q.size() < 2);
            chk("d2_out_PC", out_PC2, m_reg.pc);
            chk("d2_out_IR", out_IR2, v ? m_reg.ir : NOP);
            chk("d2_flush_cnt", flush_cnt2, cnt2);
        end
    end

    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk_en = 1;
        step(0, 0, 0, 0, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_IR", out_IR, 32'h6800_0000);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_cnt", flush_cnt, 0);

        for (int i = 0; i < 4; i++) begin
            step(1, 32'(i * 4), 1, 0, 0);
            chk("stream_pc", out_PC, 32'(i * 4));
            chk("stream_valid", out_valid, 1);
            chk("stream_ready", in_ready, 1);
        end
        step(0, 0, 1, 0, 0);
        chk("stream_end_valid", out_valid, 0);

        step(1, 32'h10, 0, 0, 0);
        chk("stall1_pc", out_PC, 32'h10);
        chk("stall1_ready", in_ready, 1);
        step(1, 32'h14, 0, 0, 0);
        chk("stall2_pc", out_PC, 32'h10);
        chk("stall2_ready", in_ready, 0);
        step(0, 0, 1, 0, 0);
        chk("release_pc", out_PC, 32'h14);
        chk("release_ready", in_ready, 1);
        step(0, 0, 1, 0, 0);
        chk("release_empty", out_valid, 0);

        step(1, 32'h20, 0, 0, 0);
        step(1, 32'h24, 0, 0, 0);
        step(1, 32'h28, 0, 1, 0);
        chk("flush_full_valid", out_valid, 0);
        chk("flush_full_IR", out_IR, 32'h6800_0000);
        chk("flush_full_cnt", flush_cnt, 2);

        step(1, 32'h30, 0, 0, 0);
        step(1, 32'h34, 0, 1, 0);
        chk("flush_one_cnt", flush_cnt, 4);
        chk("flush_one_valid", out_valid, 0);
        step(0, 0, 1, 0, 0);
        chk("flush_one_gone", out_valid, 0);

        step(1, 32'h40, 1, 0, 0);
        step(1, 32'h44, 1, 1, 0);
        chk("flush_drain_cnt", flush_cnt, 5);

        step(1, 32'h50, 0, 0, 0);
        step(1, 32'h54, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("rst_stall_cnt", flush_cnt, 0);
        chk("rst_stall_ready", in_ready, 1);
        chk("rst_stall_pc", out_PC, 0);
        step(0, 0, 0, 0, 0);

        for (int r = 0; r < 2; r++) begin
            step(1, 32'h60 + 32'(r * 16), 0, 0, 0);
            step(1, 32'h64 + 32'(r * 16), 0, 0, 0);
            step(1, 32'h68 + 32'(r * 16), 0, 1, 0);
        end
        chk("sat_cnt_w2", flush_cnt2, 3);
        chk("sat_cnt_w16", flush_cnt, 4);

        for (int i = 0; i < 40; i++)
            step(i % 3 != 0, 32'h100 + 32'(i * 4), i % 4 != 1, (i == 17) || (i == 29), 0);

        step(0, 0, 1, 0, 0);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
